// File: rtl/lcd_host.sv
// Host sequencer for an LCD image controller: issues one command per op, streams
// a 64-pixel image on load, and captures the 16-byte result frame with a timeout.
module lcd_host (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  op,
  input  logic        op_valid,
  output logic        op_ready,
  output logic [5:0]  img_addr,
  input  logic [7:0]  img_data,
  output logic [2:0]  cmd,
  output logic        cmd_valid,
  output logic [7:0]  datain,
  input  logic        busy,
  input  logic [7:0]  dataout,
  input  logic        output_valid,
  output logic        frame_done,
  output logic        frame_err,
  output logic [11:0] frame_sum,
  input  logic [3:0]  rd_idx,
  output logic [7:0]  rd_data,
  output logic [2:0]  state_dbg
);

  // Handshake: an op transfers on a rising edge where op_valid && op_ready;
  // op_ready is high only in IDLE. cmd_valid is a single-cycle strobe with no
  // back-pressure from the controller beyond busy gating its issue cycle.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    LOAD     = 3'd2,
    WAIT_OUT = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [5:0]  load_cnt;
  logic [3:0]  beat_cnt;
  logic [7:0]  idle_cnt;
  logic [11:0] acc;
  logic [7:0]  fb [16];

  assign state_dbg = state;
  assign rd_data   = fb[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    op_ready   = 1'b0;
    cmd_valid  = 1'b0;
    cmd        = 3'd0;
    img_addr   = 6'd0;
    datain     = 8'd0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (!busy) begin
          cmd_valid = 1'b1;
          cmd       = op_q;
          state_nxt = (op_q == 3'd1) ? LOAD : WAIT_OUT;
        end
      end
      LOAD: begin
        img_addr = load_cnt;
        datain   = img_data;
        if (load_cnt == 6'd63) state_nxt = WAIT_OUT;
      end
      WAIT_OUT: begin
        // A beat on the last idle cycle wins over the timeout.
        if (output_valid) begin
          if (beat_cnt == 4'd15) state_nxt = DONE;
        end else if (idle_cnt == 8'd254) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= 3'd0;
      load_cnt  <= 6'd0;
      beat_cnt  <= 4'd0;
      idle_cnt  <= 8'd0;
      acc       <= 12'd0;
      frame_sum <= 12'd0;
      frame_err <= 1'b0;
      for (int i = 0; i < 16; i++) fb[i] <= 8'd0;
    end else begin
      if (state == IDLE && op_valid) op_q <= op;

      if (state == LOAD) load_cnt <= load_cnt + 6'd1;
      else               load_cnt <= 6'd0;

      if (state == WAIT_OUT) begin
        if (output_valid) begin
          fb[beat_cnt] <= dataout;
          acc          <= acc + {4'd0, dataout};
          beat_cnt     <= beat_cnt + 4'd1;
          idle_cnt     <= 8'd0;
        end else begin
          idle_cnt <= idle_cnt + 8'd1;
        end
        // Publish the result on entry to DONE so it is valid alongside frame_done.
        if (state_nxt == DONE) begin
          frame_sum <= output_valid ? (acc + {4'd0, dataout}) : acc;
          frame_err <= ~output_valid;
        end
      end else begin
        idle_cnt <= 8'd0;
      end

      if (state == DONE) begin
        acc      <= 12'd0;
        beat_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_host.sv
// Randomised bench for lcd_host, checked against a frame-level model of the
// command, image stream and result capture behaviour.
module tb_lcd_host;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  op;
  logic        op_valid;
  logic        op_ready;
  logic [5:0]  img_addr;
  logic [7:0]  img_data;
  logic [2:0]  cmd;
  logic        cmd_valid;
  logic [7:0]  datain;
  logic        busy;
  logic [7:0]  dataout;
  logic        output_valid;
  logic        frame_done;
  logic        frame_err;
  logic [11:0] frame_sum;
  logic [3:0]  rd_idx;
  logic [7:0]  rd_data;
  logic [2:0]  state_dbg;

  lcd_host dut (
    .clk(clk), .reset(reset), .op(op), .op_valid(op_valid), .op_ready(op_ready),
    .img_addr(img_addr), .img_data(img_data), .cmd(cmd), .cmd_valid(cmd_valid),
    .datain(datain), .busy(busy), .dataout(dataout), .output_valid(output_valid),
    .frame_done(frame_done), .frame_err(frame_err), .frame_sum(frame_sum),
    .rd_idx(rd_idx), .rd_data(rd_data), .state_dbg(state_dbg)
  );

  // ---- clock / image memory ----
  always #5 clk = ~clk;

  logic [7:0] img_mem [64];
  assign img_data = img_mem[img_addr];

  // ---- scoreboard / model state ----
  int          n_checks = 0;
  int          n_errs   = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  exp_fb [16];
  logic [11:0] exp_sum;
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) exp_fb[i] = 8'd0;
    exp_sum = 12'd0;
    exp_err = 1'b0;
    exp_q.delete();
  endtask

  // ---- driver tasks ----
  task automatic do_reset();
    reset = 1'b1; op = 3'd0; op_valid = 1'b0; busy = 1'b0;
    output_valid = 1'b0; dataout = 8'd0; rd_idx = 4'd0;
    #2;
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_frame_sum", frame_sum, 0);
    step();
    step();
    reset = 1'b0;
    model_clear();
    #2;
    check("rst_op_ready", op_ready, 1);
    check("rst_cmd", cmd, 0);
    check("rst_datain", datain, 0);
    check("rst_img_addr", img_addr, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_err", frame_err, 0);
    rd_idx = 4'($urandom_range(0, 15));
    #1;
    check("rst_rd_data", rd_data, 0);
  endtask

  // One complete command: accept, issue after busy_n busy cycles, optional
  // image load, then n_beats result beats (fewer than 16 -> timeout).
  task automatic run_op(input logic [2:0] o, input int busy_n, input int n_beats, input bit all_ff);
    int          n;
    logic [7:0]  d;
    logic [11:0] prev_sum;
    logic        prev_err;
    op = o; op_valid = 1'b1;
    #2;
    check("accept_op_ready", op_ready, 1);
    check("accept_cmd_valid", cmd_valid, 0);
    step();
    op_valid = 1'b0;
    op = 3'($urandom);
    for (int i = 0; i < busy_n; i++) begin
      busy = 1'b1;
      #2;
      check("busy_cmd_valid", cmd_valid, 0);
      check("busy_op_ready", op_ready, 0);
      step();
    end
    busy = 1'b0;
    #2;
    check("issue_cmd_valid", cmd_valid, 1);
    check("issue_cmd", cmd, o);
    step();
    if (o == 3'd1) begin
      for (int k = 0; k < 64; k++) exp_q.push_back(img_mem[k]);
      for (int k = 0; k < 64; k++) begin
        output_valid = ($urandom_range(0, 3) == 0);
        dataout = 8'($urandom);
        #2;
        check("load_img_addr", img_addr, k);
        check("load_datain", datain, exp_q.pop_front());
        check("load_op_ready", op_ready, 0);
        check("load_cmd_valid", cmd_valid, 0);
        step();
      end
      output_valid = 1'b0;
    end
    exp_sum = 12'd0;
    for (int b = 0; b < n_beats; b++) begin
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) begin
        output_valid = 1'b0;
        #2;
        check("gap_frame_done", frame_done, 0);
        step();
      end
      d = all_ff ? 8'hff : 8'($urandom);
      output_valid = 1'b1;
      dataout = d;
      exp_fb[b] = d;
      exp_sum = exp_sum + 12'(d);
      #2;
      check("beat_frame_done", frame_done, 0);
      step();
    end
    output_valid = 1'b0;
    if (n_beats < 16) begin
      n = 0;
      #2;
      while (!frame_done && n < 400) begin
        n++;
        step();
        #2;
      end
      check("timeout_cycles", n, 255);
      exp_err = 1'b1;
    end else begin
      #2;
      exp_err = 1'b0;
    end
    check("done_frame_done", frame_done, 1);
    check("done_frame_sum", frame_sum, exp_sum);
    check("done_frame_err", frame_err, exp_err);
    step();
    #2;
    check("post_frame_done", frame_done, 0);
    check("post_op_ready", op_ready, 1);
    prev_sum = exp_sum;
    prev_err = exp_err;
    // Stray beats while idle must be ignored.
    for (int i = 0; i < 16; i++) begin
      output_valid = ($urandom_range(0, 1) == 1);
      dataout = 8'($urandom);
      rd_idx = 4'(i);
      #1;
      check("rd_data", rd_data, exp_fb[i]);
      step();
    end
    output_valid = 1'b0;
    #2;
    check("hold_frame_sum", frame_sum, prev_sum);
    check("hold_frame_err", frame_err, prev_err);
  endtask

  task automatic reset_mid_load();
    op = 3'd1; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    busy = 1'b0;
    #2;
    check("rml_cmd_valid", cmd_valid, 1);
    step();
    for (int k = 0; k < 30; k++) step();
    #2;
    check("rml_addr30", img_addr, 30);
    reset = 1'b1;
    #1;
    check("rml_cmd_valid_rst", cmd_valid, 0);
    check("rml_datain_rst", datain, 0);
    check("rml_img_addr_rst", img_addr, 0);
    check("rml_op_ready_rst", op_ready, 1);
    step();
    reset = 1'b0;
    model_clear();
    #2;
    check("rml_op_ready_rel", op_ready, 1);
  endtask

  // ---- main sequence ----
  initial begin
    do_reset();
    step();

    for (int k = 0; k < 64; k++) img_mem[k] = 8'(k);
    run_op(3'd1, 0, 16, 1'b0);
    run_op(3'd2, 5, 16, 1'b0);
    run_op(3'd3, 0, 16, 1'b1);
    run_op(3'd0, 0, 0, 1'b0);

    for (int k = 0; k < 64; k++) img_mem[k] = 8'($urandom);
    for (int t = 0; t < 6; t++)
      run_op(3'($urandom_range(0, 7)), $urandom_range(0, 3), 16, 1'b0);
    run_op(3'd5, 2, 5, 1'b0);

    reset_mid_load();
    run_op(3'd1, 0, 16, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_host.md
LCD_HOST -- requirements
Module: lcd_host

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high; all state cleared.
REQ-003 SHALL have port op, input, 3, controller command to issue (0 refresh, 1 load, 2 zoom-in, 3 zoom-out, 4-7 shift R/L/U/D).
REQ-004 SHALL have port op_valid, input, 1, op offered by upstream.
REQ-005 SHALL have port op_ready, output, 1, host accepts op this cycle.
REQ-006 SHALL have port img_addr, output, 6, pixel index into upstream image memory.
REQ-007 SHALL have port img_data, input, 8, pixel at img_addr, valid in the same cycle (combinational read).
REQ-008 SHALL have port cmd, output, 3, command to LCD controller.
REQ-009 SHALL have port cmd_valid, output, 1, one-cycle command strobe.
REQ-010 SHALL have port datain, output, 8, pixel stream to controller during load.
REQ-011 SHALL have port busy, input, 1, controller busy.
REQ-012 SHALL have port dataout, input, 8, controller output pixel.
REQ-013 SHALL have port output_valid, input, 1, dataout beat qualifier.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse when a command's result frame completes or times out.
REQ-015 SHALL have port frame_err, output, 1, set with frame_done on timeout; held until next frame_done.
REQ-016 SHALL have port frame_sum, output, 12, unsigned sum of the 16 captured bytes.
REQ-017 SHALL have ports rd_idx, input, 4, and rd_data, output, 8; combinational read of captured frame buffer entry rd_idx.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, LOAD, WAIT_OUT, DONE.
REQ-019 IDLE: op_ready=1; op_valid=1 SHALL latch op and go to ISSUE; op_ready=0 in all other states.
REQ-020 ISSUE: while busy=1 SHALL hold cmd_valid=0; first cycle with busy=0 SHALL drive cmd_valid=1, cmd=latched op for exactly one cycle, then go to LOAD if op=1, else WAIT_OUT.
REQ-021 LOAD: SHALL last exactly 64 cycles; cycle k (k=0..63) drives img_addr=k, datain=img_data; first LOAD cycle is the cycle immediately after the cmd_valid cycle; after k=63 go to WAIT_OUT.
REQ-022 datain SHALL be 0 outside LOAD; img_addr SHALL be 0 outside LOAD.
REQ-023 WAIT_OUT: each cycle with output_valid=1 SHALL write dataout to fb[beat], beat 0..15, and add it to a 12-bit accumulator; 16th beat SHALL go to DONE.
REQ-024 output_valid beats outside WAIT_OUT SHALL be ignored (no fb write, no sum update).
REQ-025 WAIT_OUT SHALL keep an 8-bit idle counter, cleared on each beat and on entry; reaching 255 cycles without a beat SHALL go to DONE with frame_err=1; partial fb contents retained.
REQ-026 DONE: one cycle; frame_done=1, frame_sum updated with accumulator, frame_err updated; accumulator and beat counter cleared; next state IDLE.
REQ-027 frame_sum and frame_err SHALL hold their value between DONE cycles.
REQ-028 Accumulator SHALL not overflow (16x255=4080 < 4096).

Reset
REQ-029 reset=1 SHALL force IDLE, cmd_valid=0, cmd=0, datain=0, img_addr=0, frame_done=0, frame_err=0, frame_sum=0, all fb entries 0, counters 0, asynchronously, including mid-LOAD or mid-WAIT_OUT.
REQ-030 After reset release, op_ready SHALL be 1 on the first clock edge.

Verification
REQ-031 op=1 with img_data=img_addr, busy=0 -> cmd_valid pulse cmd=1, then 64 cycles datain=0..63, op_ready low throughout.
REQ-032 op=2, busy=1 for 5 cycles -> no cmd_valid for 5 cycles, then single pulse cmd=2.
REQ-033 16 output_valid beats dataout=255 with gaps of 0-3 cycles -> frame_done one cycle, frame_sum=4080, frame_err=0, rd_data=255 for every rd_idx.
REQ-034 op=0 then no output_valid -> frame_done 255 cycles after cmd_valid-following cycle, frame_err=1.
REQ-035 reset asserted at LOAD cycle 30 -> cmd_valid=0, datain=0, op_ready=1 after release; next op=1 restarts at img_addr=0.
REQ-036 output_valid pulsed during IDLE and LOAD -> fb and frame_sum unchanged.
